mod_time_counter: RTL and testbench
===================================

// Module: mod_time_counter
// PURPOSE
//  Parametrised, fully synchronous modulo counter: the generic digit stage for the century clock (sec/min/hour/day/month/year).
//  Counts on a one-cycle advance strobe, wraps at a runtime limit, and emits a one-cycle carry/borrow strobe that feeds the next stage's inc.
//  Supports up/down direction and a synchronous load for time setting.
//  All stages share one clk; no stage is clocked by another stage's carry.
// PARAMETERS
//  WIDTH     6   count/limit/load width in bits
//  MIN_VAL   0   wrap-to value when counting up; floor when counting down (1 for day/month stages)
// PORTS
//  clk       in   1      system clock, rising edge
//  rst_n     in   1      reset, asynchronous, active-low
//  inc       in   1      advance strobe (one clk wide); ignored when low
//  dir_down  in   1      0 = count up, 1 = count down; sampled with inc
//  max_val   in   WIDTH  runtime inclusive upper limit (59 min, 23 hour, 28..31 day); must be >= MIN_VAL
//  load      in   1      synchronous load strobe
//  load_val  in   WIDTH  value written on load
//  count     out  WIDTH  current value, registered
//  carry     out  1      registered one-cycle strobe on up-wrap (max_val -> MIN_VAL) or down-wrap (MIN_VAL -> max_val)
// BEHAVIOUR
//  - Reset: count = MIN_VAL, carry = 0; applied immediately on rst_n fall, released on the next clk edge after rst_n rises.
//  - carry defaults to 0 every cycle; high for exactly one cycle, the cycle after the wrapping inc.
//  - inc && !dir_down: count >= max_val -> count = MIN_VAL, carry = 1; else count + 1.
//  - inc && dir_down: count <= MIN_VAL -> count = max_val, carry = 1; else count - 1.
//  - The >= compare is intentional: if max_val drops below count (e.g. 31 -> 28 on a month change), the next up-inc wraps with carry.
//  - load has priority over inc in the same cycle: count = clamp(load_val), carry = 0, inc is discarded.
//  - clamp(x): x > max_val -> max_val; x < MIN_VAL -> MIN_VAL; else x.
//  - No inc and no load: count holds and carry = 0.
//  - Back-to-back incs (inc high on consecutive cycles) are legal; each advances once.
//    A wrap on cycle N and a further inc on cycle N+1 give carry on N+1 only (a single pulse, not stretched).
//  - Latency: inc edge N -> count updated at N+1; carry visible at N+1, same edge as the wrapped count.
//  - Reset asserted mid-count: count and carry clear asynchronously; no carry is emitted for the interrupted state.
//  - Arithmetic is WIDTH bits unsigned. Overflow cannot occur when max_val < 2**WIDTH-1 or under the >= compare.
// CONFIGURATION
//  `MOD_COUNTER_BCD_OUT_EN defined:
//    - adds ports bcd_tens[3:0] and bcd_ones[3:0], registered, updated on the same edge as count.
//    - reset value is the BCD of MIN_VAL.
//    - valid for count <= 99; for count > 99, bcd_tens is saturated to 9 (count mod 10 still drives bcd_ones).
//  Not defined: ports absent, no BCD logic; count behaviour identical.
// STRUCTURE
//  - clock_pkg: localparams SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, MONTH_MAX=12, DAY_MIN=1, YEAR_MAX=99; WIDTH constants per stage;
//    typedef dir_t {DIR_UP, DIR_DOWN}.
//  - Sub-module bin2bcd_2d: combinational binary -> two BCD digits, instantiated only under `MOD_COUNTER_BCD_OUT_EN.
//  - Core: one next-state always_comb (load / up / down / hold mux), one always_ff with async reset.
// TESTING
//  1. Reset: rst_n=0 mid-count at 37 -> count=0, carry=0 immediately; release, no inc -> holds 0.
//  2. Up wrap: max_val=59, 60 incs from 0 -> count 0..59,0; carry high one cycle only, coincident with count=0.
//  3. Down wrap: MIN_VAL=1, max_val=31, count=1, dir_down=1, inc -> count=31, carry=1 for one cycle.
//  4. Limit shrink: count=30, max_val changed to 28, inc -> count=MIN_VAL, carry=1.
//  5. Load priority/clamp: load=1, inc=1, load_val=50, max_val=23 -> count=23, carry=0.
//  6. BCD (macro on): count 0->47 -> bcd_tens=4, bcd_ones=7 on the same edge as count; macro off -> ports absent, rest of suite passes.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants and types for the century-clock digit stages.
package clock_pkg;

    localparam int unsigned SEC_MAX   = 59;
    localparam int unsigned MIN_MAX   = 59;
    localparam int unsigned HOUR_MAX  = 23;
    localparam int unsigned MONTH_MAX = 12;
    localparam int unsigned DAY_MIN   = 1;
    localparam int unsigned YEAR_MAX  = 99;

    localparam int unsigned SEC_WIDTH   = 6;
    localparam int unsigned MIN_WIDTH   = 6;
    localparam int unsigned HOUR_WIDTH  = 5;
    localparam int unsigned DAY_WIDTH   = 5;
    localparam int unsigned MONTH_WIDTH = 4;
    localparam int unsigned YEAR_WIDTH  = 7;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/bin2bcd_2d.sv
// Combinational binary to two-digit BCD; tens digit saturates at 9 above 99.
module bin2bcd_2d #(
    parameter int unsigned WIDTH = 6
) (
    input  logic [WIDTH-1:0] bin,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    logic [31:0] bin_ext;
    logic [31:0] tens_raw;

    // Split the value into decimal digits, clamping the tens digit.
    always_comb begin
        bin_ext  = 32'(bin);
        tens_raw = bin_ext / 32'd10;
        ones     = 4'(bin_ext % 32'd10);
        if (tens_raw > 32'd9) begin
            tens = 4'd9;
        end else begin
            tens = 4'(tens_raw);
        end
    end

endmodule

// File: rtl/mod_time_counter.sv
// Generic modulo digit stage for the century clock: up/down counting on an
// advance strobe, runtime wrap limit, synchronous clamped load, and a
// registered one-cycle carry/borrow strobe for the next stage.
// Optional BCD outputs are enabled by defining MOD_COUNTER_BCD_OUT_EN.
module mod_time_counter
    import clock_pkg::*;
#(
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned MIN_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dir_down,
    input  logic [WIDTH-1:0] max_val,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
`ifdef MOD_COUNTER_BCD_OUT_EN
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
`endif
    output logic             carry
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);

    logic [WIDTH-1:0] count_d, count_q;
    logic             carry_d, carry_q;
    logic             below_min;
    dir_t             dir;

    assign dir = dir_t'(dir_down);

    // With a zero floor nothing can sit below it, so skip the compare.
    generate
        if (MIN_VAL == 0) begin : g_no_floor
            assign below_min = 1'b0;
        end else begin : g_floor
            assign below_min = (load_val < MIN_V);
        end
    endgenerate

    // Next-state mux: load (clamped) beats inc; otherwise step up/down or hold.
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        if (load) begin
            if (load_val > max_val) begin
                count_d = max_val;
            end else if (below_min) begin
                count_d = MIN_V;
            end else begin
                count_d = load_val;
            end
        end else if (inc) begin
            unique case (dir)
                DIR_UP: begin
                    if (count_q >= max_val) begin
                        count_d = MIN_V;
                        carry_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                DIR_DOWN: begin
                    if (count_q <= MIN_V) begin
                        count_d = max_val;
                        carry_d = 1'b1;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

`ifdef MOD_COUNTER_BCD_OUT_EN
    localparam int unsigned MIN_TENS = (MIN_VAL / 10 > 9) ? 9 : MIN_VAL / 10;
    localparam logic [3:0]  RST_TENS = 4'(MIN_TENS);
    localparam logic [3:0]  RST_ONES = 4'(MIN_VAL % 10);

    logic [3:0] bcd_tens_d, bcd_tens_q;
    logic [3:0] bcd_ones_d, bcd_ones_q;

    // Convert the next count so the digits land on the same edge as count.
    bin2bcd_2d #(
        .WIDTH (WIDTH)
    ) u_bin2bcd (
        .bin  (count_d),
        .tens (bcd_tens_d),
        .ones (bcd_ones_d)
    );

    // BCD digit registers with asynchronous reset to the digits of MIN_VAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_tens_q <= RST_TENS;
            bcd_ones_q <= RST_ONES;
        end else begin
            bcd_tens_q <= bcd_tens_d;
            bcd_ones_q <= bcd_ones_d;
        end
    end

    assign bcd_tens = bcd_tens_q;
    assign bcd_ones = bcd_ones_q;
`endif

    // Count and carry registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= MIN_V;
            carry_q <= 1'b0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
        end
    end

    assign count = count_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_mod_time_counter.sv
// Scoreboard bench for mod_time_counter: two instances (floor 0 and floor 1)
// share one stimulus stream; expected results are queued by the driver and
// checked by an independent monitor one cycle later.
module tb_mod_time_counter;

    localparam int W = 6;

    logic         clk;
    logic         rst_n;
    logic         inc;
    logic         dir_down;
    logic [W-1:0] max_val;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count0, count1;
    logic         carry0, carry1;
`ifdef MOD_COUNTER_BCD_OUT_EN
    logic [3:0]   tens0, ones0, tens1, ones1;
`endif

    mod_time_counter #(.WIDTH(W), .MIN_VAL(0)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (inc),
        .dir_down (dir_down),
        .max_val  (max_val),
        .load     (load),
        .load_val (load_val),
        .count    (count0),
`ifdef MOD_COUNTER_BCD_OUT_EN
        .bcd_tens (tens0),
        .bcd_ones (ones0),
`endif
        .carry    (carry0)
    );

    mod_time_counter #(.WIDTH(W), .MIN_VAL(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (inc),
        .dir_down (dir_down),
        .max_val  (max_val),
        .load     (load),
        .load_val (load_val),
        .count    (count1),
`ifdef MOD_COUNTER_BCD_OUT_EN
        .bcd_tens (tens1),
        .bcd_ones (ones1),
`endif
        .carry    (carry1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int c0;
        int k0;
        int c1;
        int k1;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m0 = 0;
    int   m1 = 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference rules: clamp on load, wrap past the limits with a carry.
    function automatic void model(input int floor_v, input int cur, input bit i, input bit d,
                                  input bit l, input int lv, input int mx,
                                  output int nxt, output int k);
        nxt = cur;
        k   = 0;
        if (l) begin
            nxt = (lv > mx) ? mx : ((lv < floor_v) ? floor_v : lv);
        end else if (i && !d) begin
            if (cur >= mx) begin nxt = floor_v; k = 1; end
            else nxt = cur + 1;
        end else if (i && d) begin
            if (cur <= floor_v) begin nxt = mx; k = 1; end
            else nxt = cur - 1;
        end
    endfunction

    // Drive one cycle from a falling edge, queue the expectation, advance.
    task automatic step(input bit i, input bit d, input bit l, input int lv, input int mx);
        exp_t e;
        inc      = i;
        dir_down = d;
        load     = l;
        load_val = W'(lv);
        max_val  = W'(mx);
        model(0, m0, i, d, l, lv, mx, e.c0, e.k0);
        model(1, m1, i, d, l, lv, mx, e.c1, e.k1);
        m0 = e.c0;
        m1 = e.c1;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every cycle the counter presents a registered result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("count0", int'(count0), e.c0);
                check("carry0", int'(carry0), e.k0);
                check("count1", int'(count1), e.c1);
                check("carry1", int'(carry1), e.k1);
`ifdef MOD_COUNTER_BCD_OUT_EN
                check("bcd_tens0", int'(tens0), (e.c0 / 10 > 9) ? 9 : e.c0 / 10);
                check("bcd_ones0", int'(ones0), e.c0 % 10);
                check("bcd_tens1", int'(tens1), (e.c1 / 10 > 9) ? 9 : e.c1 / 10);
                check("bcd_ones1", int'(ones1), e.c1 % 10);
`endif
            end
        end
    end

    initial begin
        int mx;
        rst_n    = 1'b0;
        inc      = 1'b0;
        dir_down = 1'b0;
        load     = 1'b0;
        load_val = '0;
        max_val  = W'(59);
        @(negedge clk);
        @(negedge clk);
        check("reset_count0", int'(count0), 0);
        check("reset_count1", int'(count1), 1);
        check("reset_carry0", int'(carry0), 0);
        check("reset_carry1", int'(carry1), 0);
        rst_n = 1'b1;

        // Idle after release: holds the reset value.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 59);

        // Full up sweep with a wrap at 59, then up to 37.
        for (int i = 0; i < 60; i++) step(1, 0, 0, 0, 59);
        for (int i = 0; i < 37; i++) step(1, 0, 0, 0, 59);
        check("pre_reset_count0", int'(count0), 37);

        // Asynchronous reset mid-count.
        #1 rst_n = 1'b0;
        #1;
        check("async_count0", int'(count0), 0);
        check("async_carry0", int'(carry0), 0);
        check("async_count1", int'(count1), 1);
        m0 = 0;
        m1 = 1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 59);

        // Down wrap at the floor with max 31.
        step(0, 0, 1, 1, 31);
        step(1, 1, 0, 0, 31);
        step(1, 1, 0, 0, 31);
        step(0, 1, 0, 0, 31);

        // Limit shrink below the current count forces a wrap.
        step(0, 0, 1, 30, 31);
        step(1, 0, 0, 0, 28);
        step(0, 0, 0, 0, 28);

        // Load wins over inc and is clamped to the limit.
        step(1, 0, 1, 50, 23);
        step(0, 0, 0, 0, 23);

        // Two-digit value for the BCD outputs, then load below the floor.
        step(0, 0, 1, 47, 59);
        step(0, 0, 1, 0, 59);

        // Back-to-back wraps with a tight limit.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1);

        // Randomized traffic with occasional limit changes.
        mx = 59;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0)
                mx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 63));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0, int'($urandom_range(0, 63)), mx);
        end

        step(0, 0, 0, 0, mx);
        @(posedge clk);
        #2;
        if (q.size() != 0) check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
